// File: rtl/div_s4_pkg.sv
// div_s4_pkg: shared state encoding, operand width and step count for the signed 4-bit divider
package div_s4_pkg;
  localparam int W = 4;
  localparam int STEPS = 4;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/div_u4_step.sv
// div_u4_step: one unsigned restoring step; ports r_in/d_bit/dvs in, r_out/q_bit out
module div_u4_step
  import div_s4_pkg::*;
(
  input  logic [W-1:0] r_in,
  input  logic         d_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] r_out,
  output logic         q_bit
);
  logic [W+1:0] trial;
  assign trial = {1'b0, r_in, d_bit} - {2'b00, dvs};
  assign q_bit = ~trial[W+1];
  assign r_out = q_bit ? trial[W-1:0] : {r_in[W-2:0], d_bit};
endmodule

// File: rtl/div_s4_bits.sv
// div_s4_bits: signed 4-bit sequential divider; clk/rst/start/x/y in, quot/rem/busy/done/div_by_zero/overflow out
module div_s4_bits
  import div_s4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, quot_q, quot_d, rem_q, rem_d;
  logic [1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, zero_q, zero_d, ovp_q, ovp_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [W-1:0] step_r, rv;
  logic step_b;
  div_u4_step u_step (
    .r_in  (r_q),
    .d_bit (a_q[W-1]),
    .dvs   (b_q),
    .r_out (step_r),
    .q_bit (step_b)
  );
  assign rv = zero_q ? a_q : r_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    cnt_d = cnt_q;
    sq_d = sq_q;
    sr_d = sr_q;
    zero_d = zero_q;
    ovp_d = ovp_q;
    quot_d = quot_q;
    rem_d = rem_q;
    busy_d = busy_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      a_d = x[W-1] ? -x : x;
      b_d = y[W-1] ? -y : y;
      r_d = '0;
      cnt_d = '0;
      sq_d = x[W-1] ^ y[W-1];
      sr_d = x[W-1];
      zero_d = y == '0;
      ovp_d = x == 4'h8 && y == 4'hF;
      busy_d = 1'b1;
      dbz_d = 1'b0;
      ovf_d = 1'b0;
      state_d = y == '0 ? FIX : CALC;
    end else if (state_q == CALC) begin
      a_d = {a_q[W-2:0], step_b};
      r_d = step_r;
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'(STEPS - 1) ? FIX : CALC;
    end else if (state_q == FIX) begin
      // a divide by zero leaves |x| untouched in a_q, so rem rebuilds x itself
      quot_d = zero_q ? 4'hF : (sq_q ? -a_q : a_q);
      rem_d = sr_q ? -rv : rv;
      dbz_d = zero_q;
      ovf_d = ovp_q;
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = IDLE;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      zero_q <= 1'b0;
      ovp_q <= 1'b0;
      quot_q <= '0;
      rem_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      zero_q <= zero_d;
      ovp_q <= ovp_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
    end
  end
  assign quot = quot_q;
  assign rem = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div_by_zero = dbz_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_div_s4_bits.sv
// tb_div_s4_bits: self-checking bench for div_s4_bits against a truncating arithmetic model
module tb_div_s4_bits;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [3:0] x = 4'h0;
  logic [3:0] y = 4'h0;
  logic [3:0] quot, rem;
  logic busy, done, div_by_zero, overflow;
  int checks = 0;
  int failures = 0;
  div_s4_bits dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .y           (y),
    .quot        (quot),
    .rem         (rem),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // {quot, rem, div_by_zero, overflow}
  function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b);
    int xi, yi, q, r;
    xi = int'($signed(a));
    yi = int'($signed(b));
    if (yi == 0) return {4'hF, a, 1'b1, 1'b0};
    q = xi / yi;
    r = xi % yi;
    return {4'(q), 4'(r), 1'b0, 1'(xi == -8 && yi == -1)};
  endfunction
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 20);
  endtask
  task automatic check_result(input logic [3:0] a, input logic [3:0] b, input int lat, input int exp_lat);
    logic [9:0] e;
    e = model(a, b);
    chk($sformatf("lat_%h_%h", a, b), 32'(lat), 32'(exp_lat));
    chk($sformatf("quot_%h_%h", a, b), 32'(quot), 32'(e[9:6]));
    chk($sformatf("rem_%h_%h", a, b), 32'(rem), 32'(e[5:2]));
    chk($sformatf("dbz_%h_%h", a, b), 32'(div_by_zero), 32'(e[1]));
    chk($sformatf("ovf_%h_%h", a, b), 32'(overflow), 32'(e[0]));
    chk($sformatf("busy_end_%h_%h", a, b), 32'(busy), 32'd0);
  endtask
  task automatic do_div(input logic [3:0] a, input logic [3:0] b);
    int lat;
    @(negedge clk);
    start = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("flags_cleared", 32'({div_by_zero, overflow, done}), 32'd0);
    wait_done(lat);
    check_result(a, b, lat, b == 4'h0 ? 1 : 5);
  endtask
  initial begin
    int lat;
    bit seen;
    #1 rst = 1'b1;
    #2;
    chk("reset_outs", 32'({quot, rem, busy, done, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, done}), 32'd0);
    do_div(4'h7, 4'h2);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    do_div(4'h9, 4'h2);
    do_div(4'h7, 4'hE);
    do_div(4'h8, 4'h3);
    do_div(4'h8, 4'hF);
    do_div(4'h5, 4'h0);
    do_div(4'h6, 4'h3);
    // a second start while busy must not disturb the captured operands
    @(negedge clk);
    start = 1'b1;
    x = 4'h7;
    y = 4'h2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x = 4'h3;
    y = 4'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_result(4'h7, 4'h2, lat, 3);
    // asynchronous reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1;
    x = 4'hB;
    y = 4'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", 32'({quot, rem, busy, done, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    for (int i = 0; i < 40; i++) do_div(4'($urandom), 4'($urandom));
    for (int i = 0; i < 256; i++) do_div(4'(i >> 4), 4'(i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_s4_bits.md
DIV_S4_BITS -- requirements
Module: div_s4_bits

Interface
REQ-001 No parameters; operand width is fixed at 4 bits (two's complement).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 x  input  4  signed dividend; captured on the accepted start edge.
REQ-006 y  input  4  signed divisor; captured on the accepted start edge.
REQ-007 quot  output  4  signed quotient, registered, held until the next accepted start.
REQ-008 rem  output  4  signed remainder, registered, held until the next accepted start.
REQ-009 busy  output  1  high from the accepted start edge until the result edge.
REQ-010 done  output  1  one-cycle pulse marking valid quot/rem/flags.
REQ-011 div_by_zero  output  1  sticky-until-next-start flag: y was 0.
REQ-012 overflow  output  1  sticky-until-next-start flag: x = -8 and y = -1.

Function
REQ-013 States: IDLE, CALC, FIX; reset state is IDLE.
REQ-014 IDLE: on start=1 at edge N, latch |x| and |y| as 4-bit unsigned magnitudes (|-8| = 4'b1000), latch sign_q = x[3]^y[3] and sign_r = x[3], clear done/div_by_zero/overflow, set busy, clear the 2-bit step counter, and go to CALC.
REQ-015 CALC: one restoring step per edge (shift remainder:dividend left by 1, trial-subtract |y|, restore if negative, shift result bit into the quotient); edges N+1..N+4; after the 4th step go to FIX.
REQ-016 FIX at edge N+5: quot = sign_q ? -Q : Q, rem = sign_r ? -R : R (4-bit wrap); done=1, busy=0; return to IDLE.
REQ-017 done is high exactly one cycle (between edges N+5 and N+6) and is cleared on the next edge.
REQ-018 Division truncates toward zero; the remainder takes the dividend's sign; x = quot*y + rem holds in 4-bit arithmetic.
REQ-019 Divide by zero: at edge N with y=0, skip CALC; at edge N+1 set quot=4'hF, rem=x, div_by_zero=1, done=1, busy=0.
REQ-020 Overflow: x=-8, y=-1 uses normal latency; the result is quot=4'h8 (wrapped), rem=4'h0, and overflow=1 with done.
REQ-021 start while busy is ignored; the captured operands are not disturbed.
REQ-022 start held high in IDLE across consecutive cycles launches a new division on each IDLE edge; start on the done cycle is accepted (state is IDLE).
REQ-023 x/y changes after the accepted start edge shall not affect the result.

Reset
REQ-024 rst=1 forces IDLE immediately regardless of clk, including mid-CALC; the in-flight operation is discarded.
REQ-025 Reset values: quot=0, rem=0, busy=0, done=0, div_by_zero=0, overflow=0, counter=0.
REQ-026 Deassertion of rst leaves the block in IDLE; no done pulse is generated for the aborted operation.

Structure
REQ-027 Package div_s4_pkg holds the state enumeration, the operand width constant (4), and the step count constant (4).
REQ-028 One sub-module div_u4_step (combinational single restoring step: partial remainder, dividend bit, divisor in; new remainder and quotient bit out) is instantiated once and reused per CALC cycle.
REQ-029 Sign handling and magnitude conversion live in div_s4_bits; no other sub-modules.

Verification
REQ-030 x=7, y=2, start at edge N -> done at N+5, quot=4'h3, rem=4'h1, flags 0.
REQ-031 x=-7 (4'h9), y=2 -> quot=4'hD (-3), rem=4'hF (-1); then x=7, y=-2 -> quot=4'hD, rem=4'h1.
REQ-032 x=-8, y=3 -> quot=4'hE (-2), rem=4'hE (-2); x=-8, y=-1 -> quot=4'h8, rem=0, overflow=1.
REQ-033 x=5, y=0 -> done at N+1, quot=4'hF, rem=4'h5, div_by_zero=1; the next valid start clears the flag.
REQ-034 start pulsed again at N+2 with different operands -> ignored; the result matches the first operands. rst asserted at N+3 -> all outputs 0 asynchronously, and no done follows.
REQ-035 Exhaustive sweep over all 256 (x,y) pairs, back-to-back starts on done -> every result matches the truncating reference model and every latency is 5 (or 1 for y=0).
